// File: rtl/hssi_tc_mailbox_bridge.sv
// Host CSR mailbox (CMD/ADDRESS/RDDATA/WRDATA) that issues one traffic-controller
// register access at a time and aborts reads or writes that exceed a cycle budget.
module hssi_tc_mailbox_bridge #(
    parameter int unsigned TC_ADDR_W   = 16,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 csr_wr,
    input  logic                 csr_rd,
    input  logic [3:0]           csr_addr,
    input  logic [31:0]          csr_wdata,
    output logic [31:0]          csr_rdata,
    output logic                 csr_rdata_valid,
    output logic [TC_ADDR_W-1:0] tc_addr,
    output logic                 tc_write,
    output logic                 tc_read,
    output logic [31:0]          tc_wdata,
    input  logic                 tc_waitrequest,
    input  logic [31:0]          tc_readdata,
    input  logic                 tc_readdatavalid
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    localparam logic [3:0] OFS_CMD    = 4'h0;
    localparam logic [3:0] OFS_ADDR   = 4'h4;
    localparam logic [3:0] OFS_RDDATA = 4'h8;
    localparam logic [3:0] OFS_WRDATA = 4'hC;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE_WR = 2'd1,
        ST_ISSUE_RD = 2'd2,
        ST_WAIT_RD  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wrdata;
    logic [DATA_W-1:0]   r_rddata;
    logic                r_ack;
    logic                r_timeout;
    logic                r_cmd_err;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_tc_write;
    logic                r_tc_read;
    logic [DATA_W-1:0]   r_csr_rdata;
    logic                r_csr_rdata_valid;

    logic [DATA_W-1:0]   w_addr_nxt;
    logic [DATA_W-1:0]   w_wrdata_nxt;
    logic [DATA_W-1:0]   w_rddata_nxt;
    logic                w_ack_nxt;
    logic                w_timeout_nxt;
    logic                w_cmd_err_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_cnt_last;
    logic                w_busy;
    logic                w_act_rd;
    logic                w_act_wr;
    logic [DATA_W-1:0]   w_cmd_word;
    logic [DATA_W-1:0]   w_rd_mux;

    assign w_cnt_last = (r_cnt == CNT_LAST);
    assign w_busy     = (r_state != ST_IDLE);
    assign w_act_wr   = (r_state == ST_ISSUE_WR);
    assign w_act_rd   = (r_state == ST_ISSUE_RD) || (r_state == ST_WAIT_RD);
    assign w_cmd_word = {26'd0, r_cmd_err, r_timeout, w_busy, r_ack, w_act_wr, w_act_rd};

    // Next-state and register updates; the timeout check yields to a same-cycle completion.
    always_comb begin
        w_state_nxt   = r_state;
        w_addr_nxt    = r_addr;
        w_wrdata_nxt  = r_wrdata;
        w_rddata_nxt  = r_rddata;
        w_ack_nxt     = r_ack;
        w_timeout_nxt = r_timeout;
        w_cmd_err_nxt = r_cmd_err;
        w_cnt_nxt     = r_cnt + CNT_W'(1);
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (csr_wr && (csr_addr == OFS_ADDR)) begin
                    w_addr_nxt = csr_wdata;
                end
                if (csr_wr && (csr_addr == OFS_WRDATA)) begin
                    w_wrdata_nxt = csr_wdata;
                end
                if (csr_wr && (csr_addr == OFS_CMD)) begin
                    case (csr_wdata[1:0])
                        2'b01: begin
                            w_state_nxt   = ST_ISSUE_RD;
                            w_ack_nxt     = 1'b0;
                            w_timeout_nxt = 1'b0;
                            w_cmd_err_nxt = 1'b0;
                        end
                        2'b10: begin
                            w_state_nxt   = ST_ISSUE_WR;
                            w_ack_nxt     = 1'b0;
                            w_timeout_nxt = 1'b0;
                            w_cmd_err_nxt = 1'b0;
                        end
                        2'b11: begin
                            w_cmd_err_nxt = 1'b1;
                            w_ack_nxt     = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_ISSUE_WR: begin
                if (!tc_waitrequest) begin
                    w_state_nxt = ST_IDLE;
                    w_ack_nxt   = 1'b1;
                end else if (w_cnt_last) begin
                    w_state_nxt   = ST_IDLE;
                    w_ack_nxt     = 1'b1;
                    w_timeout_nxt = 1'b1;
                end
            end
            ST_ISSUE_RD: begin
                // Accepting the read is not a completion, so the budget still applies.
                if (w_cnt_last) begin
                    w_state_nxt   = ST_IDLE;
                    w_ack_nxt     = 1'b1;
                    w_timeout_nxt = 1'b1;
                end else if (!tc_waitrequest) begin
                    w_state_nxt = ST_WAIT_RD;
                end
            end
            ST_WAIT_RD: begin
                if (tc_readdatavalid) begin
                    w_state_nxt  = ST_IDLE;
                    w_rddata_nxt = tc_readdata;
                    w_ack_nxt    = 1'b1;
                end else if (w_cnt_last) begin
                    w_state_nxt   = ST_IDLE;
                    w_ack_nxt     = 1'b1;
                    w_timeout_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Host read mux samples the registers before any same-cycle write lands.
    always_comb begin
        case (csr_addr)
            OFS_CMD:    w_rd_mux = w_cmd_word;
            OFS_ADDR:   w_rd_mux = r_addr;
            OFS_RDDATA: w_rd_mux = r_rddata;
            OFS_WRDATA: w_rd_mux = r_wrdata;
            default:    w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state           <= ST_IDLE;
            r_addr            <= '0;
            r_wrdata          <= '0;
            r_rddata          <= '0;
            r_ack             <= 1'b0;
            r_timeout         <= 1'b0;
            r_cmd_err         <= 1'b0;
            r_cnt             <= '0;
            r_tc_write        <= 1'b0;
            r_tc_read         <= 1'b0;
            r_csr_rdata       <= '0;
            r_csr_rdata_valid <= 1'b0;
        end else begin
            r_state           <= w_state_nxt;
            r_addr            <= w_addr_nxt;
            r_wrdata          <= w_wrdata_nxt;
            r_rddata          <= w_rddata_nxt;
            r_ack             <= w_ack_nxt;
            r_timeout         <= w_timeout_nxt;
            r_cmd_err         <= w_cmd_err_nxt;
            r_cnt             <= w_cnt_nxt;
            r_tc_write        <= (w_state_nxt == ST_ISSUE_WR);
            r_tc_read         <= (w_state_nxt == ST_ISSUE_RD);
            r_csr_rdata       <= csr_rd ? w_rd_mux : '0;
            r_csr_rdata_valid <= csr_rd;
        end
    end

    assign tc_write        = r_tc_write;
    assign tc_read         = r_tc_read;
    assign tc_addr         = r_addr[TC_ADDR_W-1:0];
    assign tc_wdata        = r_wrdata;
    assign csr_rdata       = r_csr_rdata;
    assign csr_rdata_valid = r_csr_rdata_valid;

endmodule
